// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// op codes, default latencies, FSM encoding and op-class helpers.
package md_pkg;

  localparam int MD_OPW        = 4;
  localparam int MD_MUL_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;

  typedef logic [MD_OPW-1:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MADD  = 4'd7;
  localparam md_op_t MD_MSUB  = 4'd8;
  localparam md_op_t MD_MFHI  = 4'd9;
  localparam md_op_t MD_MFLO  = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } md_state_e;

  function automatic logic is_md_class(input md_op_t op);
    return (op >= MD_MULT) && (op <= MD_MFLO);
  endfunction

  function automatic logic is_md_issue(input md_op_t op);
    return (op >= MD_MULT) && (op <= MD_MSUB);
  endfunction

  function automatic logic is_mul(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Loadable down-counter shadowing the mul/div unit latency.
// expire_o pulses while the count sits at 1.
module md_lat_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage requester for the mul/div unit: one-cycle op issue,
// shadow latency tracking and HI/LO dependency stall.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_CYCLES = MD_MUL_CYCLES,
  parameter int DIV_CYCLES = MD_DIV_CYCLES,
  parameter int OPW        = MD_OPW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_op,
  input  logic [31:0]     id_rs,
  input  logic [31:0]     id_rt,
  input  logic            ex_flush,
  input  logic            md_busy,
  output logic [OPW-1:0]  md_op,
  output logic [31:0]     md_a,
  output logic [31:0]     md_b,
  output logic            stall,
  output logic            run
);

  localparam int CW = $clog2(DIV_CYCLES + 2);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES + 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES + 1);

  md_state_e      state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic           stall_c;
  logic           acc;
  logic           ld;
  logic [CW-1:0]  ld_val;
  logic           expire;

  md_lat_cnt #(
    .W (CW)
  ) u_cnt (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (ld),
    .val_i    (ld_val),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    op_d    = '0;
    a_d     = a_q;
    b_d     = b_q;
    ld      = 1'b0;
    ld_val  = '0;
    // md_busy is only a backstop; the shadow FSM should cover it
    stall_c = id_valid & is_md_class(id_op)
            & ((state_q != IDLE) | (op_q != '0) | md_busy);
    acc     = id_valid & is_md_issue(id_op) & ~stall_c & ~ex_flush;
    if (acc) begin
      op_d = id_op;
      a_d  = id_rs;
      b_d  = id_rt;
      unique case (1'b1)
        is_mul(id_op): begin
          state_d = MUL_RUN;
          ld      = 1'b1;
          ld_val  = MUL_LD;
        end
        is_div(id_op): begin
          state_d = DIV_RUN;
          ld      = 1'b1;
          ld_val  = DIV_LD;
        end
        default: ;
      endcase
    end else if ((state_q != IDLE) && expire) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign md_op = op_q;
  assign md_a  = a_q;
  assign md_b  = b_q;
  assign stall = stall_c;
  assign run   = (state_q != IDLE);

endmodule
